// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding, default slice width and chunk-count helper
package adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int SLICE_DEF = 6;
  // Returns 0 when width is not a positive whole number of slices, so the
  // instantiating block can reject the configuration at elaboration.
  function automatic int chunk_count(input int width, input int slice);
    return (slice > 0 && width >= slice && width % slice == 0) ? width / slice : 0;
  endfunction
endpackage

// File: rtl/chunk_add.sv
// chunk_add: combinational SLICE-bit adder with carry in/out
//   a, b : SLICE-bit addends   cin : carry in
//   s    : SLICE-bit sum       cout: carry out
module chunk_add #(
  parameter int SLICE = 6
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  output logic [SLICE-1:0] s,
  output logic             cout
);
  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SLICE{1'b0}}, cin};
endmodule

// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle WIDTH-bit adder, one SLICE-bit chunk per clock
//   clk, rst_n                   : clock, async active-low reset
//   in_valid/in_ready            : operand handshake (in_a, in_b, in_cin)
//   out_valid/out_ready          : result handshake (out_sum, out_cout)
//   busy                         : high while chunks are being added
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int SLICE = SLICE_DEF,
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             busy
);
  localparam int NCHUNK = chunk_count(WIDTH, SLICE);
  localparam int KW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  if (NCHUNK < 1) begin : g_bad_cfg
    $error("seq_chunk_adder: WIDTH must be a positive multiple of SLICE");
  end

  state_t           state, state_nxt;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_r, b_r;
  logic [SLICE-1:0] s;
  logic             c;
  logic             accept, last;

  chunk_add #(.SLICE(SLICE)) u_chunk (
    .a   (a_r[k*SLICE +: SLICE]),
    .b   (b_r[k*SLICE +: SLICE]),
    .cin (carry),
    .s   (s),
    .cout(c)
  );

  // Gated by rst_n so upstream never sees ready while reset is held.
  assign in_ready  = rst_n && (state == IDLE || (state == DONE && out_ready));
  assign accept    = in_valid && in_ready;
  assign last      = state == RUN && k == KW'(NCHUNK - 1);
  assign out_valid = state == DONE;
  assign busy      = state == RUN;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = accept ? RUN : IDLE;
      RUN:     state_nxt = last ? DONE : RUN;
      DONE:    state_nxt = accept ? RUN : out_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      k        <= '0;
      carry    <= 1'b0;
      a_r      <= '0;
      b_r      <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_r   <= in_a;
        b_r   <= in_b;
        carry <= in_cin;
        k     <= '0;
      end else if (state == RUN) begin
        out_sum[k*SLICE +: SLICE] <= s;
        carry                     <= c;
        k                         <= k + 1'b1;
        if (last) out_cout <= c;
      end
    end
  end
endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb_seq_chunk_adder: directed self-checking bench for seq_chunk_adder
module tb_seq_chunk_adder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_a = '0;
  logic [23:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] out_sum;
  logic        out_cout;
  logic        busy;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic [23:0] sum;
    logic        cout;
  } vec_t;

  seq_chunk_adder dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_cout (out_cout),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Called at a negedge; returns 1ns after the accept edge.
  task automatic start_op(input logic [23:0] a, input logic [23:0] b, input logic cin);
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_valid = 1'b1;
    chk("start_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after the accept edge until out_valid, bounded.
  task automatic wait_done(output int lat, output int busy_cycles);
    lat = 0;
    busy_cycles = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cycles++;
      @(posedge clk);
      #1;
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("consume_valid_drop", out_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    vec_t tv[7];
    int lat, bc, bad;
    logic [23:0] held;
    tv[0] = '{24'hFFFFFF, 24'h000001, 1'b0, 24'h000000, 1'b1};
    tv[1] = '{24'hFFFFFF, 24'h000000, 1'b1, 24'h000000, 1'b1};
    tv[2] = '{24'hFFFFFF, 24'h000000, 1'b0, 24'hFFFFFF, 1'b0};
    tv[3] = '{24'h123456, 24'h0FEDCB, 1'b0, 24'h222221, 1'b0};
    tv[4] = '{24'h800000, 24'h800000, 1'b1, 24'h000001, 1'b1};
    tv[5] = '{24'h555555, 24'hAAAAAA, 1'b1, 24'h000000, 1'b1};
    tv[6] = '{24'h000000, 24'h000000, 1'b0, 24'h000000, 1'b0};

    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_cout", out_cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      start_op(tv[i].a, tv[i].b, tv[i].cin);
      wait_done(lat, bc);
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_busy_cycles", i), bc, 4);
      chk($sformatf("vec%0d_sum", i), out_sum, tv[i].sum);
      chk($sformatf("vec%0d_cout", i), out_cout, tv[i].cout);
      consume();
    end

    // Backpressure then same-edge consume and capture.
    start_op(24'h00000F, 24'h000001, 1'b0);
    wait_done(lat, bc);
    chk("bp_sum", out_sum, 24'h000010);
    held = out_sum;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_sum !== held || out_cout !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("bp_stable_bad_cycles", bad, 0);
    out_ready = 1'b1;
    in_a = 24'h000100;
    in_b = 24'h000200;
    in_cin = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("bp_in_ready_follows_out_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("bp_b2b_valid_drop", out_valid, 0);
    chk("bp_b2b_busy", busy, 1);
    wait_done(lat, bc);
    chk("bp_b2b_latency", lat, 4);
    chk("bp_b2b_sum", out_sum, 24'h000300);
    consume();

    // Input changes and in_valid during RUN are ignored.
    start_op(24'h000010, 24'h000020, 1'b0);
    @(negedge clk);
    in_a = 24'hFFFFFF;
    in_b = 24'hFFFFFF;
    in_valid = 1'b1;
    #1;
    chk("run_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    chk("run_ignore_sum", out_sum, 24'h000030);
    chk("run_ignore_cout", out_cout, 0);
    @(negedge clk);
    consume();
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("run_no_extra_result", bad, 0);

    // Reset in the cycle after E2.
    start_op(24'h00ABCD, 24'h001111, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_sum", out_sum, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst_no_valid_pulse", bad, 0);
    rst_n = 1'b1;
    #1;
    chk("midrst_release_in_ready", in_ready, 1);
    @(negedge clk);
    start_op(24'h000001, 24'h000002, 1'b0);
    wait_done(lat, bc);
    chk("midrst_fresh_latency", lat, 4);
    chk("midrst_fresh_sum", out_sum, 24'h000003);
    chk("midrst_fresh_cout", out_cout, 0);
    consume();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Multi-cycle wide adder that splits WIDTH-bit operands into SLICE-bit chunks and adds one chunk per clock.
- Ripples the carry between chunks through a register, LSB chunk first.
- Sits around the 6-bit slice adder: captures operands from an upstream producer, drives the slice, and presents a registered result downstream.
- Uses valid/ready handshakes on both sides.

Parameters:
- SLICE, 6: chunk width in bits; matches the slice adder.
- WIDTH, 24: operand width. Must be an integer multiple of SLICE, with WIDTH/SLICE >= 1; checked at elaboration.
- NCHUNK, WIDTH/SLICE: derived chunk count. Local only, not overridable.

Ports:
- clk, input, 1: single clock; all state updates on rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: upstream offers operands.
- in_ready, output, 1: block can accept operands this cycle.
- in_a, input, WIDTH: operand A.
- in_b, input, WIDTH: operand B.
- in_cin, input, 1: carry-in to chunk 0.
- out_valid, output, 1: result held and valid.
- out_ready, input, 1: downstream consumes result.
- out_sum, output, WIDTH: registered sum.
- out_cout, output, 1: carry out of the top chunk.
- busy, output, 1: high in RUN.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, out_valid=0, out_sum=0, out_cout=0, busy=0.
  - Chunk index and carry register = 0; operand registers = 0.
  - in_ready=0 while rst_n=0; it rises combinationally in IDLE after release.
- States:
  - IDLE: in_ready=1. in_valid&in_ready captures in_a, in_b, in_cin into operand/carry registers, clears chunk index k=0, goes to RUN.
  - RUN: busy=1, in_ready=0.
    - Each cycle: {c, s} = a[k] + b[k] + carry, computed in SLICE+1 bits.
    - s is written to sum chunk k and c to the carry register; k increments.
    - When k==NCHUNK-1 that cycle: write the last chunk, set out_cout=c, out_valid=1, go to DONE.
  - DONE: out_valid=1. out_sum/out_cout are stable until the handshake.
    - out_ready=1 with no new input: out_valid drops next edge, go to IDLE.
    - in_ready = out_ready (combinational). If out_ready & in_valid in the same cycle, the result is consumed and new operands are captured on the same edge; go directly to RUN.
- Latency: accept edge E0; chunk k is written at edge E(k+1); out_valid is high from edge E(NCHUNK). Default config gives 4 cycles.
- Throughput: one operation per NCHUNK+1 cycles with back-to-back handshakes.
- Arithmetic:
  - Unsigned modulo 2^WIDTH; out_cout is the true carry.
  - Carry between chunks is exact (SLICE+1-bit add).
  - The carry register is never reset between chunks of one operation.
- out_sum is updated chunk-by-chunk in RUN. It is only meaningful while out_valid=1; downstream must not sample it otherwise.
- Upstream changes to in_a/in_b after acceptance are ignored (operands are registered).
- in_valid in RUN: ignored, no capture; upstream holds it.
- out_ready in IDLE/RUN: ignored.
- Reset asserted mid-RUN or in DONE: immediate return to IDLE with all outputs cleared. The partial result is discarded and no out_valid pulse occurs.
- NCHUNK=1: RUN lasts one cycle; DONE is reached at E1.

Decomposition:
- Shared package (adder_pkg):
  - state enum {IDLE, RUN, DONE}.
  - SLICE default constant.
  - Function computing chunk count with the divisibility check.
- One sub-module: chunk_add, a purely combinational SLICE-bit adder with cin/cout, instantiated once and time-multiplexed over chunks.
- The FSM and registers stay in seq_chunk_adder.

Test Plan:
- Full carry ripple: a=0xFFFFFF, b=0x000001, cin=0 → out_valid at E4; sum=0x000000, cout=1; busy high for exactly 4 cycles.
- Carry-in through all chunks: a=0xFFFFFF, b=0, cin=1 → sum=0x000000, cout=1. Same operands with cin=0 → sum=0xFFFFFF, cout=0.
- Mixed values: a=0x123456, b=0x0FEDCB, cin=0 → sum=0x222221, cout=0.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid → sum/cout stable, in_ready=0 throughout. Then out_ready=1 with in_valid=1 and new operands → new op captured on the same edge; next result valid 4 cycles later.
- Input ignored in RUN: change in_a and pulse in_valid during RUN → result reflects the originally captured operands; no extra result produced.
- Reset mid-op: assert rst_n=0 at the cycle after E2 → out_valid=0, busy=0 immediately. After release, in_ready=1 and a fresh op (a=1, b=2) → sum=3, cout=0.
